// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, presents {pc, instr} to decode
// on a valid/ready handshake and asks the PC to advance on acceptance.
module fetch_stage #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(fetch_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc_en,
  input  logic              flush,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_fault
);
  import fetch_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              if_fault_q, if_fault_d;
  logic              aligned;

  assign aligned = (pc_in[1:0] == 2'b00);

  // Next-state, next-output and handshake logic.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_valid_d     = if_valid_q;
    if_pc_d        = if_pc_q;
    if_instr_d     = if_instr_q;
    if_fault_d     = if_fault_q;
    pc_inc_en      = 1'b0;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_in;

    case (state_q)
      ST_REQ: begin
        imem_req_valid = aligned & ~rst;
        if (aligned) begin
          if (imem_req_ready) begin
            pc_d    = pc_in;
            state_d = flush ? ST_DROP : ST_WAIT;
          end
        end else if (!flush) begin
          // Misaligned PC: report a fault with a NOP instead of fetching.
          if_valid_d = 1'b1;
          if_fault_d = 1'b1;
          if_instr_d = NOP_INSTR;
          if_pc_d    = pc_in;
          state_d    = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (!flush) begin
            if_valid_d = 1'b1;
            if_fault_d = 1'b0;
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_REQ;
          end
        end else if (flush) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      ST_HOLD: begin
        // Flush wins over a same-cycle accept.
        if (flush) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (if_ready) begin
          pc_inc_en  = if_valid_q;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_fault_q <= if_fault_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_fault = if_fault_q;

`ifndef SYNTHESIS
  // A response with no request outstanding means the memory broke protocol.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (state_q == ST_REQ || state_q == ST_HOLD)))
        else $error("fetch_stage: imem_rsp_valid with no request outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshakes, stalls, flushes, misaligned PC, reset.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_inc_en;
  logic              flush;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_instr;
  logic              if_fault;

  int checks;
  int errors;

  fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_inc_en      (pc_inc_en),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then reflect the new state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pc_in = '0;
    flush = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if_ready = 1'b0;

    // Reset values while rst is held
    #2;
    chk("rst_if_valid", 64'(if_valid), 64'(0));
    chk("rst_if_pc", 64'(if_pc), 64'(0));
    chk("rst_if_instr", 64'(if_instr), 64'h13);
    chk("rst_if_fault", 64'(if_fault), 64'(0));
    chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
    chk("rst_pc_inc", 64'(pc_inc_en), 64'(0));
    tick();
    rst = 1'b0;

    // Basic fetch at 0x100, minimum latency
    pc_in = 32'h100; imem_req_ready = 1'b1; if_ready = 1'b1;
    settle();
    chk("basic_req_valid", 64'(imem_req_valid), 64'(1));
    chk("basic_req_addr", 64'(imem_req_addr), 64'h100);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    settle();
    chk("basic_wait_req_valid", 64'(imem_req_valid), 64'(0));
    chk("basic_wait_if_valid", 64'(if_valid), 64'(0));
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    chk("basic_if_valid", 64'(if_valid), 64'(1));
    chk("basic_if_pc", 64'(if_pc), 64'h100);
    chk("basic_if_instr", 64'(if_instr), 64'h0050_0093);
    chk("basic_if_fault", 64'(if_fault), 64'(0));
    chk("basic_pc_inc", 64'(pc_inc_en), 64'(1));
    tick();
    pc_in = 32'h100 + PC_STEP;
    settle();
    chk("basic_pc_inc_once", 64'(pc_inc_en), 64'(0));
    chk("basic_if_valid_clr", 64'(if_valid), 64'(0));
    chk("basic_next_req_valid", 64'(imem_req_valid), 64'(1));
    chk("basic_next_addr", 64'(imem_req_addr), 64'h104);

    // Backpressure: decode stalls 5 cycles
    if_ready = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0113;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_if_valid", 64'(if_valid), 64'(1));
      chk("bp_if_pc", 64'(if_pc), 64'h104);
      chk("bp_if_instr", 64'(if_instr), 64'h00A0_0113);
      chk("bp_pc_inc", 64'(pc_inc_en), 64'(0));
      chk("bp_req_valid", 64'(imem_req_valid), 64'(0));
      tick();
    end
    if_ready = 1'b1;
    settle();
    chk("bp_accept_pc_inc", 64'(pc_inc_en), 64'(1));
    tick();
    pc_in = 32'h108;
    settle();
    chk("bp_after_pc_inc", 64'(pc_inc_en), 64'(0));
    chk("bp_after_if_valid", 64'(if_valid), 64'(0));

    // Memory stall: request held 3 cycles, slow response
    if_ready = 1'b0; imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_req_valid", 64'(imem_req_valid), 64'(1));
      chk("stall_req_addr", 64'(imem_req_addr), 64'h108);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_wait_if_valid", 64'(if_valid), 64'(0));
      tick();
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_8193;
    settle();
    chk("stall_rsp_if_valid", 64'(if_valid), 64'(0));
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    chk("stall_if_valid", 64'(if_valid), 64'(1));
    chk("stall_if_pc", 64'(if_pc), 64'h108);
    chk("stall_if_instr", 64'(if_instr), 64'h0020_8193);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;

    // Flush in WAIT: 0xDEADBEEF is dropped, redirect to 0x400
    pc_in = 32'h200; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; pc_in = 32'h400;
    settle();
    chk("flw_drop_req_valid", 64'(imem_req_valid), 64'(0));
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    settle();
    chk("flw_drop_if_valid", 64'(if_valid), 64'(0));
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    chk("flw_if_valid", 64'(if_valid), 64'(0));
    chk("flw_if_instr_kept", 64'(if_instr), 64'h0020_8193);
    chk("flw_req_valid", 64'(imem_req_valid), 64'(1));
    chk("flw_req_addr", 64'(imem_req_addr), 64'h400);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0073;
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    chk("flw_new_if_valid", 64'(if_valid), 64'(1));
    chk("flw_new_if_pc", 64'(if_pc), 64'h400);
    chk("flw_new_if_instr", 64'(if_instr), 64'h0000_0073);

    // Flush + if_ready in HOLD: flush wins
    if_ready = 1'b1; flush = 1'b1;
    settle();
    chk("flh_pc_inc", 64'(pc_inc_en), 64'(0));
    tick();
    if_ready = 1'b0; flush = 1'b0; pc_in = 32'h800;
    settle();
    chk("flh_if_valid", 64'(if_valid), 64'(0));
    chk("flh_req_valid", 64'(imem_req_valid), 64'(1));
    chk("flh_req_addr", 64'(imem_req_addr), 64'h800);

    // Flush + rsp_valid same cycle in WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_C0DE; flush = 1'b1;
    tick();
    imem_rsp_valid = 1'b0; flush = 1'b0; pc_in = 32'h900;
    settle();
    chk("flr_if_valid", 64'(if_valid), 64'(0));
    chk("flr_pc_inc", 64'(pc_inc_en), 64'(0));
    chk("flr_req_valid", 64'(imem_req_valid), 64'(1));
    chk("flr_req_addr", 64'(imem_req_addr), 64'h900);

    // Misaligned PC
    pc_in = 32'h102;
    settle();
    chk("mis_req_valid", 64'(imem_req_valid), 64'(0));
    tick();
    settle();
    chk("mis_if_valid", 64'(if_valid), 64'(1));
    chk("mis_if_fault", 64'(if_fault), 64'(1));
    chk("mis_if_instr", 64'(if_instr), 64'h13);
    chk("mis_if_pc", 64'(if_pc), 64'h102);
    chk("mis_hold_req_valid", 64'(imem_req_valid), 64'(0));
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0; pc_in = 32'h200;

    // Reset asserted mid-WAIT takes effect without a clock edge
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    settle();
    chk("pre_rst_req_valid", 64'(imem_req_valid), 64'(0));
    rst = 1'b1;
    settle();
    chk("arst_if_valid", 64'(if_valid), 64'(0));
    chk("arst_if_pc", 64'(if_pc), 64'(0));
    chk("arst_if_instr", 64'(if_instr), 64'h13);
    chk("arst_if_fault", 64'(if_fault), 64'(0));
    chk("arst_req_valid", 64'(imem_req_valid), 64'(0));
    chk("arst_pc_inc", 64'(pc_inc_en), 64'(0));
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_req_valid", 64'(imem_req_valid), 64'(1));
    chk("post_rst_req_addr", 64'(imem_req_addr), 64'h200);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC and issues one instruction-memory request at a time. It waits a variable latency for the response, then presents {pc, instr} to decode on a valid/ready handshake.
- Pulses pc_inc_en back to the PC when decode accepts an instruction.
- Handles pipeline flush (redirect) by discarding the in-flight response.

Parameters:
ADDR_W, 32, PC / instruction memory address width
DATA_W, 32, instruction width
NOP_INSTR, 32'h0000_0013, value driven on if_instr at reset and on fault (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pc_in  in  ADDR_W  current PC from program counter
pc_inc_en  out  1  combinational; 1-cycle request to advance PC by 4
flush  in  1  redirect from branch/jump; PC is loaded the same edge
imem_req_valid  out  1  instruction memory request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  request address
imem_rsp_valid  in  1  response valid, 1 cycle pulse
imem_rsp_data  in  DATA_W  fetched instruction
if_valid  out  1  fetched instruction valid to decode
if_ready  in  1  decode accepts
if_pc  out  ADDR_W  PC of presented instruction
if_instr  out  DATA_W  presented instruction
if_fault  out  1  instruction-address-misaligned flag

Behaviour:
- Reset values (async assert):
  - State REQ; if_valid=0, if_pc=0, if_instr=NOP_INSTR, if_fault=0.
  - Internal pc_q=0; imem_req_valid=0 while rst high.
- Only one request is outstanding at a time. Responses arrive ≥1 cycle after request acceptance.
- States: REQ, WAIT, HOLD, DROP (registered, 2-bit encoding in package).
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc_in, unless pc_in[1:0]!=0.
  - Misaligned case: no request issued. Next cycle goes to HOLD with if_valid=1, if_fault=1, if_instr=NOP_INSTR, if_pc=pc_in.
  - Aligned and imem_req_ready=1: pc_q<=pc_in; next state WAIT (or DROP if flush the same cycle).
  - imem_req_valid held and imem_req_addr stable until accepted, unless flush. Flush in REQ without handshake stays in REQ; the next cycle uses the new pc_in.
- WAIT:
  - imem_rsp_valid=1 and flush=0: if_instr<=data, if_pc<=pc_q, if_fault<=0, if_valid<=1; next state HOLD.
  - imem_rsp_valid=1 and flush=1: discard data; next state REQ.
  - flush=1 without a response: next state DROP.
- DROP: wait for imem_rsp_valid, discard data, then go to REQ. A flush in DROP has no extra effect.
- HOLD:
  - if_valid=1; outputs stable until accepted.
  - if_ready=1 and flush=0: pc_inc_en=1 this cycle, if_valid<=0, next state REQ. The PC updates on the same edge, so REQ sees PC+4.
  - flush=1: if_valid<=0, pc_inc_en=0, next state REQ (flush beats if_ready).
- pc_inc_en = (state==HOLD) & if_valid & if_ready & ~flush. It never asserts in any other state.
- imem_rsp_valid in REQ or HOLD is a protocol violation: ignored, with a simulation assertion.
- Minimum latency, aligned fetch with req_ready=1 and response 1 cycle later:
  - cycle 0 request accepted;
  - cycle 1 response;
  - cycle 2 if_valid=1.
- Throughput: 1 instruction per 3 cycles at best. No prefetch, by decision.
- Reset mid-operation: returns immediately to reset values. Any outstanding memory response after reset release arrives in REQ and is ignored (memory is reset by the same rst).

Decomposition:
- Package fetch_pkg: state enum (REQ, WAIT, HOLD, DROP), NOP_INSTR constant, PC_STEP=4.
- No sub-module. The output register set is inline in the FSM module.

Test Plan:
- Basic fetch:
  - Stimulus: pc_in=0x0000_0100, req_ready=1, response 0x00500093 one cycle after acceptance, if_ready=1.
  - Response: if_valid at cycle 2 with if_pc=0x100, if_instr=0x00500093; pc_inc_en single pulse; next request addr=0x104.
- Backpressure:
  - Stimulus: if_ready=0 for 5 cycles after if_valid.
  - Response: if_pc/if_instr stable, pc_inc_en=0 throughout, no new imem request. Accepted on the 6th cycle with exactly one pc_inc_en pulse.
- Memory stall:
  - Stimulus: req_ready=0 for 3 cycles, then response 4 cycles after acceptance.
  - Response: imem_req_addr constant while stalled; if_valid exactly one cycle after rsp_valid.
- Flush in WAIT:
  - Stimulus: request 0x200 accepted, flush with pc_in→0x400, response 0xDEADBEEF two cycles later.
  - Response: 0xDEADBEEF never appears on if_instr; next request addr=0x400; if_valid=0 until the 0x400 response.
- Flush + rsp_valid same cycle in WAIT, and flush + if_ready same cycle in HOLD:
  - Response: no if_valid for the dropped instruction, pc_inc_en=0, state REQ.
- Misaligned + reset:
  - Stimulus: pc_in=0x102.
  - Response: no imem_req_valid; if_valid=1, if_fault=1, if_instr=0x00000013, if_pc=0x102.
  - Then assert rst mid-WAIT: all outputs at reset values immediately (async), imem_req_valid=0.
